boot_sequencer: RTL and testbench

//  Sequences bootloader power-up, USB core reset release and the exit to the user image.

---
 rtl/boot_sequencer.sv | 166 ++++++++++++++++
 tb/tb_boot_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// boot_sequencer: holds the USB core in reset until the PLL settles, opens a
// bounded enumeration window, then warm-boots into the user image on timeout
// or after an accepted DFU detach (deferred while a flash write is in flight).
module boot_sequencer #(
  parameter logic [31:0] RESET_CYCLES = 32'd12000,
  parameter logic [31:0] BOOT_TIMEOUT = 32'd36000000,
  parameter logic [31:0] DETACH_DELAY = 32'd12000,
  parameter logic [1:0]  USER_IMAGE   = 2'b01
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       usb_active,
  input  logic       dfu_detach,
  input  logic       dfu_busy,
  output logic       core_reset,
  output logic       boot,
  output logic [1:0] boot_img,
  output logic [2:0] seq_state
);

  typedef enum logic [2:0] {
    ST_LOCK_WAIT   = 3'd0,
    ST_RESET       = 3'd1,
    ST_WAIT_HOST   = 3'd2,
    ST_STAY        = 3'd3,
    ST_DETACH_WAIT = 3'd4,
    ST_BOOT        = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] cnt_r, cnt_s;
  logic [31:0] cnt_dec_s;
  logic        cnt_last_s;
  logic        detach_pend_r, detach_pend_s;
  logic        core_reset_r, core_reset_s;
  logic        boot_r, boot_s;
  logic [1:0]  boot_img_r;

  // Saturating countdown: a zero count (BOOT_TIMEOUT==0) stays frozen and never expires.
  always_comb begin
    cnt_dec_s  = cnt_r;
    cnt_last_s = (cnt_r == 32'd1);
    if (cnt_r != 32'd0) begin
      cnt_dec_s = cnt_r - 32'd1;
    end else begin
      cnt_dec_s = cnt_r;
    end
  end

  // Next-state, counter reload and next output values.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    detach_pend_s = detach_pend_r;
    core_reset_s  = core_reset_r;
    boot_s        = boot_r;
    case (state_r)
      ST_LOCK_WAIT: begin
        core_reset_s = 1'b1;
        if (pll_locked) begin
          state_s = ST_RESET;
          cnt_s   = RESET_CYCLES;
        end else begin
          state_s = ST_LOCK_WAIT;
        end
      end
      ST_RESET: begin
        core_reset_s = 1'b1;
        cnt_s        = cnt_dec_s;
        if (!pll_locked) begin
          state_s = ST_LOCK_WAIT;
          cnt_s   = 32'd0;
        end else if (cnt_last_s) begin
          state_s      = ST_WAIT_HOST;
          cnt_s        = BOOT_TIMEOUT;
          core_reset_s = 1'b0;
        end else begin
          state_s = ST_RESET;
        end
      end
      ST_WAIT_HOST: begin
        cnt_s = cnt_dec_s;
        if (!pll_locked) begin
          state_s      = ST_LOCK_WAIT;
          cnt_s        = 32'd0;
          core_reset_s = 1'b1;
        end else if (dfu_detach) begin
          state_s = ST_DETACH_WAIT;
          cnt_s   = DETACH_DELAY;
        end else if (usb_active) begin
          // Activity beats a same-cycle timeout: an attached host is never dropped.
          state_s = ST_STAY;
          cnt_s   = 32'd0;
        end else if (cnt_last_s) begin
          state_s = ST_BOOT;
          boot_s  = 1'b1;
        end else begin
          state_s = ST_WAIT_HOST;
        end
      end
      ST_STAY: begin
        if (dfu_detach || detach_pend_r) begin
          if (dfu_busy) begin
            detach_pend_s = 1'b1;
          end else begin
            state_s       = ST_DETACH_WAIT;
            cnt_s         = DETACH_DELAY;
            detach_pend_s = 1'b0;
          end
        end else begin
          state_s = ST_STAY;
        end
      end
      ST_DETACH_WAIT: begin
        if (cnt_last_s) begin
          if (!dfu_busy) begin
            state_s = ST_BOOT;
            boot_s  = 1'b1;
          end else begin
            // Hold at the last count until the flash write completes.
            cnt_s = cnt_r;
          end
        end else begin
          cnt_s = cnt_dec_s;
        end
      end
      ST_BOOT: begin
        state_s = ST_BOOT;
        boot_s  = 1'b1;
      end
      default: begin
        state_s       = ST_LOCK_WAIT;
        cnt_s         = 32'd0;
        detach_pend_s = 1'b0;
        core_reset_s  = 1'b1;
        boot_s        = 1'b0;
      end
    endcase
  end

  // State, counter and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= ST_LOCK_WAIT;
      cnt_r         <= 32'd0;
      detach_pend_r <= 1'b0;
      core_reset_r  <= 1'b1;
      boot_r        <= 1'b0;
      boot_img_r    <= USER_IMAGE;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      detach_pend_r <= detach_pend_s;
      core_reset_r  <= core_reset_s;
      boot_r        <= boot_s;
      boot_img_r    <= USER_IMAGE;
    end
  end

  assign core_reset = core_reset_r;
  assign boot       = boot_r;
  assign boot_img   = boot_img_r;
  assign seq_state  = state_r;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: two instances (timeout 20 and
// timeout 0) share stimulus; a cycle-age reference model checks every cycle,
// plus a vector table, directed corner sequences and random stimulus.
module tb_boot_sequencer;

  localparam int RC  = 4;
  localparam int BT  = 20;
  localparam int DD  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pll_locked = 1'b0;
  logic usb_active = 1'b0;
  logic dfu_detach = 1'b0;
  logic dfu_busy = 1'b0;

  logic       cr_a, boot_a, cr_z, boot_z;
  logic [1:0] img_a, img_z;
  logic [2:0] seq_a, seq_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  boot_sequencer #(
    .RESET_CYCLES(32'd4), .BOOT_TIMEOUT(32'd20), .DETACH_DELAY(32'd3), .USER_IMAGE(2'b01)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .usb_active(usb_active),
    .dfu_detach(dfu_detach), .dfu_busy(dfu_busy), .core_reset(cr_a), .boot(boot_a),
    .boot_img(img_a), .seq_state(seq_a)
  );

  boot_sequencer #(
    .RESET_CYCLES(32'd4), .BOOT_TIMEOUT(32'd0), .DETACH_DELAY(32'd3), .USER_IMAGE(2'b01)
  ) dut_z (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .usb_active(usb_active),
    .dfu_detach(dfu_detach), .dfu_busy(dfu_busy), .core_reset(cr_z), .boot(boot_z),
    .boot_img(img_z), .seq_state(seq_z)
  );

  // Reference model: phase number plus cycles spent in the phase.
  typedef struct {
    int st;
    int age;
    bit pend;
    bit cr;
    bit bt;
  } mdl_t;

  mdl_t m_a = '{0, 0, 1'b0, 1'b1, 1'b0};
  mdl_t m_z = '{0, 0, 1'b0, 1'b1, 1'b0};

  function automatic mdl_t mstep(input mdl_t m, input int tmo,
                                 input bit rn, input bit pl, input bit ua,
                                 input bit dt, input bit db);
    mdl_t n = m;
    if (!rn) begin
      n.st = 0; n.age = 0; n.pend = 1'b0; n.cr = 1'b1; n.bt = 1'b0;
      return n;
    end
    case (m.st)
      0: if (pl) begin n.st = 1; n.age = 0; end
      1: begin
        n.age = m.age + 1;
        if (!pl) n.st = 0;
        else if (n.age == RC) begin n.st = 2; n.age = 0; n.cr = 1'b0; end
      end
      2: begin
        n.age = m.age + 1;
        if (!pl) begin n.st = 0; n.cr = 1'b1; end
        else if (dt) begin n.st = 4; n.age = 0; end
        else if (ua) n.st = 3;
        else if (tmo != 0 && n.age == tmo) begin n.st = 5; n.bt = 1'b1; end
      end
      3: if (dt || m.pend) begin
        if (db) n.pend = 1'b1;
        else begin n.st = 4; n.age = 0; n.pend = 1'b0; end
      end
      4: begin
        if (m.age < DD) n.age = m.age + 1;
        if (n.age >= DD && !db) begin n.st = 5; n.bt = 1'b1; end
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // One clock: step both models with the held inputs, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    m_a = mstep(m_a, BT, reset_n, pll_locked, usb_active, dfu_detach, dfu_busy);
    m_z = mstep(m_z, 0,  reset_n, pll_locked, usb_active, dfu_detach, dfu_busy);
    @(negedge clk);
    check("mdl_state_a", int'(seq_a), m_a.st);
    check("mdl_creset_a", int'(cr_a), int'(m_a.cr));
    check("mdl_boot_a", int'(boot_a), int'(m_a.bt));
    check("mdl_img_a", int'(img_a), 1);
    check("mdl_state_z", int'(seq_z), m_z.st);
    check("mdl_creset_z", int'(cr_z), int'(m_z.cr));
    check("mdl_boot_z", int'(boot_z), int'(m_z.bt));
  endtask

  task automatic drive(input bit rn, input bit pl, input bit ua, input bit dt, input bit db);
    reset_n = rn; pll_locked = pl; usb_active = ua; dfu_detach = dt; dfu_busy = db;
  endtask

  // Reset, lock, and run until instance A releases core_reset (bounded).
  task automatic bring_up(input bit db);
    int n;
    drive(1'b0, 1'b0, 1'b0, 1'b0, db); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, db);
    n = 0;
    while (cr_a == 1'b1 && n < 30) begin tick(); n++; end
    check("bring_up_release", int'(cr_a), 0);
  endtask

  typedef struct {
    bit rn, pl, ua, dt, db;
    logic [2:0] st;
    bit cr, bt;
  } vec_t;

  vec_t vt [0:19];

  initial begin
    int n;
    int cnt1;
    bit seen;

    vt[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
    vt[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};
    vt[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
    vt[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
    vt[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1};
    vt[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b1};
    vt[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};

    @(negedge clk);

    // Vector table: lock, countdown, stay, deferred detach, boot, reset.
    for (int i = 0; i < 20; i++) begin
      drive(vt[i].rn, vt[i].pl, vt[i].ua, vt[i].dt, vt[i].db);
      tick();
      check($sformatf("vec%0d_state_a", i), int'(seq_a), int'(vt[i].st));
      check($sformatf("vec%0d_creset_a", i), int'(cr_a), int'(vt[i].cr));
      check($sformatf("vec%0d_boot_a", i), int'(boot_a), int'(vt[i].bt));
      check($sformatf("vec%0d_state_z", i), int'(seq_z), int'(vt[i].st));
    end

    // Auto-boot 20 cycles after core_reset release, even with dfu_busy held.
    bring_up(1'b1);
    n = 0;
    while (boot_a == 1'b0 && n < 40) begin tick(); n++; end
    check("timeout_latency", n, BT);
    check("timeout_img", int'(img_a), 1);
    check("timeout_z_no_boot", int'(boot_z), 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (boot_a == 1'b0) seen = 1'b1;
    end
    check("boot_held_100", int'(seen), 0);

    // Activity on the expiry cycle wins: STAY, no boot for 1000 cycles.
    bring_up(1'b0);
    for (int i = 0; i < BT - 1; i++) tick();
    usb_active = 1'b1; tick(); usb_active = 1'b0;
    check("expiry_activity_state", int'(seq_a), 3);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (boot_a == 1'b1) seen = 1'b1;
    end
    check("stay_no_boot_1000", int'(seen), 0);
    check("stay_state", int'(seq_a), 3);

    // Detach while busy is deferred; boot 3 cycles after DETACH_WAIT entry.
    dfu_busy = 1'b1; dfu_detach = 1'b1; tick(); dfu_detach = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("busy_detach_state", int'(seq_a), 3);
    dfu_busy = 1'b0; tick();
    check("detach_wait_entry", int'(seq_a), 4);
    n = 0;
    while (boot_a == 1'b0 && n < 20) begin tick(); n++; end
    check("detach_latency", n, DD);

    // Reset while booted returns everything to reset values.
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    check("rst_boot_a", int'(boot_a), 0);
    check("rst_creset_a", int'(cr_a), 1);
    check("rst_state_a", int'(seq_a), 0);

    // PLL drop during RESET: back to LOCK_WAIT, then full reset replayed.
    pll_locked = 1'b1; tick(); tick();
    pll_locked = 1'b0; tick();
    check("pll_drop_reset_state", int'(seq_a), 0);
    check("pll_drop_reset_cr", int'(cr_a), 1);
    pll_locked = 1'b1;
    cnt1 = 0; n = 0;
    while (seq_a != 3'd2 && n < 20) begin
      tick(); n++;
      if (seq_a == 3'd1) cnt1++;
    end
    check("replay_reset_len1", cnt1, RC);

    // PLL drop during WAIT_HOST: core_reset reasserted and reset replayed.
    tick(); tick();
    pll_locked = 1'b0; tick();
    check("pll_drop_host_state", int'(seq_a), 0);
    check("pll_drop_host_cr", int'(cr_a), 1);
    pll_locked = 1'b1;
    cnt1 = 0; n = 0;
    while (seq_a != 3'd2 && n < 20) begin
      tick(); n++;
      if (seq_a == 3'd1) cnt1++;
    end
    check("replay_reset_len2", cnt1, RC);

    // BOOT_TIMEOUT=0 instance never auto-boots.
    bring_up(1'b0);
    for (int i = 0; i < 200; i++) tick();
    check("z_never_boot", int'(boot_z), 0);
    check("z_still_waiting", int'(seq_z), 2);
    check("a_booted", int'(boot_a), 1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 4000; i++) begin
      reset_n    = ($urandom_range(199) != 0);
      pll_locked = ($urandom_range(63) != 0);
      usb_active = ($urandom_range(63) == 0);
      dfu_detach = ($urandom_range(31) == 0);
      if ($urandom_range(7) == 0) dfu_busy = ~dfu_busy;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
